// File: rtl/ucode_sequencer_gen.sv
// Microcode sequencer: next micro-address selection, micro-flag register and optional return stack.
// Optional return stack enabled by defining UCODE_SEQ_STACK_EN.
module ucode_sequencer_gen #(
  parameter int unsigned          UADDR_W       = 14,
  parameter int unsigned          OFFSET_W      = 7,
  parameter int unsigned          IR_W          = 8,
  parameter int unsigned          STACK_DEPTH   = 4,
  parameter logic [UADDR_W-1:0]   FETCH_U_ADDR  = UADDR_W'('h10),
  parameter logic [UADDR_W-1:0]   TRAP_U_ADDR   = UADDR_W'('h20),
  parameter logic [UADDR_W-1:0]   DISPATCH_BASE = '0,
  localparam int unsigned         LVL_W         = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                stall,
  input  logic [2:0]          typ,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [3:0]          cond_sel,
  input  logic                cond_invert,
  input  logic                cond_flag_src,
  input  logic [1:0]          u_zf_in_src,
  input  logic [1:0]          u_cf_in_src,
  input  logic                u_sf_in_src,
  input  logic                u_of_in_src,
  input  logic [IR_W-1:0]     ir,
  input  logic [3:0]          alu_flags,
  input  logic                alu_final_cf,
  input  logic                alu_of,
  input  logic [7:0]          alu_out,
  input  logic [7:0]          z_bus,
  input  logic [6:0]          cond_ext,
  input  logic                dma_req,
  input  logic                int_pending,
  output logic [UADDR_W-1:0]  u_address,
  output logic [3:0]          u_flags,
  output logic [LVL_W-1:0]    stack_level,
  output logic                stack_err
);

  localparam logic [2:0] TYP_REL    = 3'b000;
  localparam logic [2:0] TYP_COND   = 3'b001;
  localparam logic [2:0] TYP_FETCH  = 3'b010;
  localparam logic [2:0] TYP_DISP   = 3'b011;
  localparam logic [2:0] TYP_CALL   = 3'b100;
  localparam logic [2:0] TYP_RET    = 3'b101;
  localparam logic [2:0] TYP_ABS    = 3'b110;

  logic [UADDR_W-1:0]        u_address_q, u_address_d;
  logic [3:0]                u_flags_q, u_flags_d;
  logic signed [OFFSET_W-1:0] off_s_c;
  logic [UADDR_W-1:0]        seq_c, br_c, disp_c, irq_tgt_c;
  logic [3:0]                cflags_c;
  logic                      cond_raw_c, cond_c;
  logic                      unused_c;

  assign unused_c = ^{alu_out[6:1], z_bus[6:0]};

  assign off_s_c   = offset;
  assign seq_c     = u_address_q + UADDR_W'(1);
  assign br_c      = u_address_q + UADDR_W'(off_s_c);
  assign disp_c    = DISPATCH_BASE + UADDR_W'(ir);
  assign irq_tgt_c = (dma_req | int_pending) ? TRAP_U_ADDR : FETCH_U_ADDR;
  assign cflags_c  = cond_flag_src ? u_flags_q : alu_flags;

  // Branch condition from the pre-edge flag set ({of,sf,cf,zf}) or external conditions
  always_comb begin
    cond_raw_c = 1'b0;
    case (cond_sel)
      4'd0:    cond_raw_c = cflags_c[0];
      4'd1:    cond_raw_c = cflags_c[1];
      4'd2:    cond_raw_c = cflags_c[2];
      4'd3:    cond_raw_c = cflags_c[3];
      4'd4:    cond_raw_c = cflags_c[2] ^ cflags_c[3];
      4'd5:    cond_raw_c = (cflags_c[2] ^ cflags_c[3]) | cflags_c[0];
      4'd6:    cond_raw_c = cflags_c[1] | cflags_c[0];
      4'd7:    cond_raw_c = cond_ext[0];
      4'd8:    cond_raw_c = cond_ext[1];
      4'd9:    cond_raw_c = cond_ext[2];
      4'd10:   cond_raw_c = cond_ext[3];
      4'd11:   cond_raw_c = cond_ext[4];
      4'd12:   cond_raw_c = cond_ext[5];
      4'd13:   cond_raw_c = cond_ext[6];
      default: cond_raw_c = 1'b0;
    endcase
  end

  assign cond_c = cond_raw_c ^ cond_invert;

`ifdef UCODE_SEQ_STACK_EN
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               err_q, err_d;
  logic               push_c;
  logic [UADDR_W-1:0] top_c;

  assign top_c = stack_q[PTR_W'(lvl_q - LVL_W'(1))];
`endif

  // Next-state: stall freezes address, flags and stack
  always_comb begin
    u_address_d = u_address_q;
    u_flags_d   = u_flags_q;
`ifdef UCODE_SEQ_STACK_EN
    lvl_d       = lvl_q;
    err_d       = err_q;
    push_c      = 1'b0;
`endif
    if (!stall) begin
      case (typ)
        TYP_REL:   u_address_d = br_c;
        TYP_COND:  u_address_d = cond_c ? br_c : seq_c;
        TYP_FETCH: u_address_d = irq_tgt_c;
        TYP_DISP:  u_address_d = disp_c;
`ifdef UCODE_SEQ_STACK_EN
        TYP_CALL: begin
          u_address_d = br_c;
          if (lvl_q == LVL_W'(STACK_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            push_c = 1'b1;
            lvl_d  = lvl_q + LVL_W'(1);
          end
        end
        TYP_RET: begin
          if (lvl_q == '0) begin
            u_address_d = FETCH_U_ADDR;
            err_d       = 1'b1;
          end else begin
            u_address_d = top_c;
            lvl_d       = lvl_q - LVL_W'(1);
          end
        end
`else
        TYP_CALL:  u_address_d = br_c;
        TYP_RET:   u_address_d = irq_tgt_c;
`endif
        TYP_ABS:   u_address_d = UADDR_W'(offset);
        default:   u_address_d = u_address_q;
      endcase

      case (u_zf_in_src)
        2'b01:   u_flags_d[0] = alu_flags[0];
        2'b10:   u_flags_d[0] = alu_flags[0] & u_flags_q[0];
        default: u_flags_d[0] = u_flags_q[0];
      endcase
      case (u_cf_in_src)
        2'b01:   u_flags_d[1] = alu_final_cf;
        2'b10:   u_flags_d[1] = alu_out[0];
        2'b11:   u_flags_d[1] = alu_out[7];
        default: u_flags_d[1] = u_flags_q[1];
      endcase
      if (u_sf_in_src) u_flags_d[2] = z_bus[7];
      if (u_of_in_src) u_flags_d[3] = alu_of;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      u_address_q <= '0;
      u_flags_q   <= '0;
    end else begin
      u_address_q <= u_address_d;
      u_flags_q   <= u_flags_d;
    end
  end

`ifdef UCODE_SEQ_STACK_EN
  always_ff @(posedge clk) begin
    if (arst) begin
      lvl_q <= '0;
      err_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      err_q <= err_d;
    end
  end

  // Stack contents are not reset; only the level pointer qualifies them
  always_ff @(posedge clk) begin
    if (!arst && push_c) stack_q[PTR_W'(lvl_q)] <= seq_c;
  end

  assign stack_level = lvl_q;
  assign stack_err   = err_q;
`else
  assign stack_level = '0;
  assign stack_err   = 1'b0;
`endif

  assign u_address = u_address_q;
  assign u_flags   = u_flags_q;

endmodule

// File: tb/tb_ucode_sequencer_gen.sv
// Directed table-driven bench for ucode_sequencer_gen, with hand sequences for flags and the return stack.
module tb_ucode_sequencer_gen;

  logic        clk = 1'b0;
  logic        arst, stall, cond_invert, cond_flag_src;
  logic [2:0]  typ;
  logic [6:0]  offset;
  logic [3:0]  cond_sel;
  logic [1:0]  u_zf_in_src, u_cf_in_src;
  logic        u_sf_in_src, u_of_in_src;
  logic [7:0]  ir;
  logic [3:0]  alu_flags;
  logic        alu_final_cf, alu_of;
  logic [7:0]  alu_out, z_bus;
  logic [6:0]  cond_ext;
  logic        dma_req, int_pending;
  logic [13:0] u_address;
  logic [3:0]  u_flags;
  logic [1:0]  stack_level;
  logic        stack_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ucode_sequencer_gen #(
    .STACK_DEPTH   (2),
    .DISPATCH_BASE (14'h100)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .stall         (stall),
    .typ           (typ),
    .offset        (offset),
    .cond_sel      (cond_sel),
    .cond_invert   (cond_invert),
    .cond_flag_src (cond_flag_src),
    .u_zf_in_src   (u_zf_in_src),
    .u_cf_in_src   (u_cf_in_src),
    .u_sf_in_src   (u_sf_in_src),
    .u_of_in_src   (u_of_in_src),
    .ir            (ir),
    .alu_flags     (alu_flags),
    .alu_final_cf  (alu_final_cf),
    .alu_of        (alu_of),
    .alu_out       (alu_out),
    .z_bus         (z_bus),
    .cond_ext      (cond_ext),
    .dma_req       (dma_req),
    .int_pending   (int_pending),
    .u_address     (u_address),
    .u_flags       (u_flags),
    .stack_level   (stack_level),
    .stack_err     (stack_err)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [2:0]  typ;
    logic [6:0]  off;
    logic [3:0]  csel;
    logic        cinv;
    logic        csrc;
    logic [3:0]  af;
    logic [7:0]  ir;
    logic        irq;
    logic        dma;
    logic [6:0]  cext;
    logic [13:0] exp;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  task automatic apply(input vec_t v);
    arst = v.rst; stall = v.stl; typ = v.typ; offset = v.off;
    cond_sel = v.csel; cond_invert = v.cinv; cond_flag_src = v.csrc;
    alu_flags = v.af; ir = v.ir; int_pending = v.irq; dma_req = v.dma; cond_ext = v.cext;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    apply(v);
    tick();
    chk(nm, 32'(u_address), 32'(v.exp));
  endtask

  initial begin
    // rst stl typ off csel cinv csrc af ir irq dma cext exp
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000};
    tbl[1]  = '{1'b0, 1'b0, 3'b000, 7'h05, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0005};
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 7'h05, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h000A};
    tbl[3]  = '{1'b0, 1'b0, 3'b000, 7'h05, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h000F};
    tbl[4]  = '{1'b0, 1'b0, 3'b110, 7'h10, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0010};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 7'h7E, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h000E};
    tbl[6]  = '{1'b1, 1'b1, 3'b110, 7'h33, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000};
    tbl[7]  = '{1'b0, 1'b0, 3'b000, 7'h7F, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h3FFF};
    tbl[8]  = '{1'b0, 1'b0, 3'b000, 7'h01, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000};
    tbl[9]  = '{1'b0, 1'b0, 3'b110, 7'h20, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0020};
    tbl[10] = '{1'b0, 1'b0, 3'b001, 7'h04, 4'd0,  1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0024};
    tbl[11] = '{1'b0, 1'b0, 3'b110, 7'h20, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0020};
    tbl[12] = '{1'b0, 1'b0, 3'b001, 7'h04, 4'd0,  1'b1, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0021};
    tbl[13] = '{1'b0, 1'b0, 3'b010, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 7'h00, 14'h0020};
    tbl[14] = '{1'b0, 1'b0, 3'b010, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0010};
    tbl[15] = '{1'b0, 1'b0, 3'b011, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'hA5, 1'b0, 1'b0, 7'h00, 14'h01A5};
    tbl[16] = '{1'b0, 1'b1, 3'b011, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'h3C, 1'b0, 1'b0, 7'h00, 14'h01A5};
    tbl[17] = '{1'b0, 1'b1, 3'b010, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 7'h00, 14'h01A5};
    tbl[18] = '{1'b0, 1'b0, 3'b111, 7'h15, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h01A5};
    tbl[19] = '{1'b0, 1'b0, 3'b001, 7'h02, 4'd4,  1'b0, 1'b0, 4'h4, 8'h00, 1'b0, 1'b0, 7'h00, 14'h01A7};
    tbl[20] = '{1'b0, 1'b0, 3'b001, 7'h02, 4'd5,  1'b0, 1'b0, 4'hC, 8'h00, 1'b0, 1'b0, 7'h00, 14'h01A8};
    tbl[21] = '{1'b0, 1'b0, 3'b001, 7'h03, 4'd6,  1'b0, 1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 7'h00, 14'h01AB};
    tbl[22] = '{1'b0, 1'b0, 3'b001, 7'h7C, 4'd9,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h04, 14'h01A7};
    tbl[23] = '{1'b0, 1'b0, 3'b001, 7'h7C, 4'd9,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h7B, 14'h01A8};
    tbl[24] = '{1'b0, 1'b0, 3'b001, 7'h04, 4'd14, 1'b0, 1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 7'h7F, 14'h01A9};
    tbl[25] = '{1'b0, 1'b0, 3'b001, 7'h04, 4'd15, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h01AD};
    tbl[26] = '{1'b0, 1'b0, 3'b001, 7'h04, 4'd1,  1'b0, 1'b0, 4'hD, 8'h00, 1'b0, 1'b0, 7'h00, 14'h01AE};
    tbl[27] = '{1'b0, 1'b0, 3'b001, 7'h40, 4'd3,  1'b0, 1'b0, 4'h8, 8'h00, 1'b0, 1'b0, 7'h00, 14'h016E};
    tbl[28] = '{1'b0, 1'b0, 3'b001, 7'h02, 4'd13, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h40, 14'h0170};
    tbl[29] = '{1'b0, 1'b0, 3'b010, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 7'h00, 14'h0020};
    tbl[30] = '{1'b0, 1'b0, 3'b011, 7'h00, 4'd0,  1'b0, 1'b0, 4'h0, 8'hFF, 1'b0, 1'b0, 7'h00, 14'h01FF};

    u_zf_in_src = 2'b00; u_cf_in_src = 2'b00; u_sf_in_src = 1'b0; u_of_in_src = 1'b0;
    alu_final_cf = 1'b0; alu_of = 1'b0; alu_out = 8'h00; z_bus = 8'h00;
    apply(tbl[0]);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i], $sformatf("vec%0d addr", i));
      if (i == 0) begin
        chk("reset flags", 32'(u_flags), 32'h0);
        chk("reset level", 32'(stack_level), 32'h0);
        chk("reset err", 32'(stack_err), 32'h0);
      end
    end

    // Micro-flag update selects, stall hold, and condition using pre-edge u_flags
    u_cf_in_src = 2'b11; alu_out = 8'h80;
    step('{1'b0, 1'b0, 3'b110, 7'h50, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0050}, "flag1 addr");
    chk("cf from alu_out[7]", 32'(u_flags), 32'h2);
    u_zf_in_src = 2'b01; u_cf_in_src = 2'b00; u_sf_in_src = 1'b1; u_of_in_src = 1'b1; z_bus = 8'h80; alu_of = 1'b1;
    step('{1'b0, 1'b0, 3'b111, 7'h00, 4'd0, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0050}, "flag2 addr");
    chk("zf/sf/of load", 32'(u_flags), 32'hF);
    u_zf_in_src = 2'b10; u_cf_in_src = 2'b10; u_sf_in_src = 1'b0; u_of_in_src = 1'b0; alu_of = 1'b0; z_bus = 8'h00;
    step('{1'b0, 1'b0, 3'b111, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0050}, "flag3 addr");
    chk("zf and, cf alu_out[0]", 32'(u_flags), 32'hC);
    u_zf_in_src = 2'b01; u_cf_in_src = 2'b01; alu_final_cf = 1'b1;
    step('{1'b0, 1'b1, 3'b110, 7'h7F, 4'd0, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0050}, "stall addr");
    chk("stall flags held", 32'(u_flags), 32'hC);
    u_zf_in_src = 2'b11;
    step('{1'b0, 1'b0, 3'b111, 7'h00, 4'd0, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0050}, "flag5 addr");
    chk("zf 11 hold, final_cf", 32'(u_flags), 32'hE);
    u_zf_in_src = 2'b00; u_cf_in_src = 2'b00; u_sf_in_src = 1'b1; z_bus = 8'h00;
    step('{1'b0, 1'b0, 3'b001, 7'h03, 4'd2, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0053}, "u_sf pre-edge taken");
    chk("sf cleared after edge", 32'(u_flags), 32'hA);
    step('{1'b0, 1'b0, 3'b001, 7'h03, 4'd2, 1'b0, 1'b1, 4'h4, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0054}, "u_sf clear not taken");
    u_sf_in_src = 1'b0;

`ifdef UCODE_SEQ_STACK_EN
    // Depth-2 stack: overflow, ordered returns, underflow, reset during call/return
    step('{1'b1, 1'b0, 3'b000, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000}, "stk reset");
    step('{1'b0, 1'b0, 3'b110, 7'h30, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0030}, "stk goto 30");
    step('{1'b0, 1'b0, 3'b100, 7'h10, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0040}, "call1");
    chk("call1 level", 32'(stack_level), 32'h1);
    step('{1'b0, 1'b1, 3'b100, 7'h10, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0040}, "stalled call");
    chk("stalled call level", 32'(stack_level), 32'h1);
    step('{1'b0, 1'b0, 3'b100, 7'h10, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0050}, "call2");
    chk("call2 level", 32'(stack_level), 32'h2);
    chk("call2 err", 32'(stack_err), 32'h0);
    step('{1'b0, 1'b0, 3'b100, 7'h10, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0060}, "call3 full");
    chk("call3 level", 32'(stack_level), 32'h2);
    chk("call3 err", 32'(stack_err), 32'h1);
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0041}, "ret1");
    chk("ret1 level", 32'(stack_level), 32'h1);
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0031}, "ret2");
    chk("ret2 level", 32'(stack_level), 32'h0);
    chk("err sticky", 32'(stack_err), 32'h1);
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0010}, "ret3 empty");
    step('{1'b1, 1'b0, 3'b000, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000}, "stk reset2");
    chk("reset clears err", 32'(stack_err), 32'h0);
    step('{1'b0, 1'b0, 3'b110, 7'h30, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0030}, "stk goto 30b");
    step('{1'b0, 1'b0, 3'b100, 7'h10, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0040}, "call4");
    step('{1'b1, 1'b1, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000}, "reset during ret");
    chk("reset during ret level", 32'(stack_level), 32'h0);
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0010}, "ret after reset");
    chk("ret after reset err", 32'(stack_err), 32'h1);
`else
    // Without the stack, call is a relative branch and return is a fetch dispatch
    step('{1'b1, 1'b0, 3'b000, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000}, "nostk reset");
    step('{1'b0, 1'b0, 3'b110, 7'h30, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0030}, "nostk goto 30");
    step('{1'b0, 1'b0, 3'b100, 7'h10, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0040}, "nostk call");
    chk("nostk level", 32'(stack_level), 32'h0);
    chk("nostk err", 32'(stack_err), 32'h0);
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0010}, "nostk ret fetch");
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 7'h00, 14'h0020}, "nostk ret trap");
    step('{1'b1, 1'b1, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 7'h00, 14'h0000}, "nostk reset during ret");
    step('{1'b0, 1'b0, 3'b101, 7'h00, 4'd0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 7'h00, 14'h0020}, "nostk ret dma");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer_gen.md
UCODE_SEQUENCER_GEN -- requirements
Module: ucode_sequencer_gen

Interface
REQ-001 Parameter UADDR_W, default 14, sets the micro-address width.
REQ-002 Parameter OFFSET_W, default 7, sets the branch offset width; range 2..UADDR_W.
REQ-003 Parameter IR_W, default 8, sets the opcode width; range 1..UADDR_W.
REQ-004 Parameter STACK_DEPTH, default 4, sets micro-return stack entries; range 1..16.
REQ-005 Parameters FETCH_U_ADDR and TRAP_U_ADDR, each UADDR_W wide, default 'h10 / 'h20, set the dispatch targets.
REQ-006 Parameter DISPATCH_BASE, UADDR_W wide, default 0, is added to the opcode on IR dispatch.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 arst  in  1  reset; synchronous, active-high, sampled only on the rising edge of clk.
REQ-009 stall  in  1  high holds u_address, u_flags and the stack unchanged.
REQ-010 typ  in  3  sequencing type of the current control word.
REQ-011 offset  in  OFFSET_W  two's-complement branch offset, or absolute target for typ 110.
REQ-012 cond_sel  in  4; cond_invert  in  1; cond_flag_src  in  1 (1 = u_flags, 0 = alu_flags).
REQ-013 u_zf_in_src  in  2; u_cf_in_src  in  2; u_sf_in_src  in  1; u_of_in_src  in  1: u_flags update selects.
REQ-014 ir  in  IR_W  opcode register value.
REQ-015 alu_flags  in  4  {of,sf,cf,zf}; alu_final_cf  in  1; alu_of  in  1; alu_out  in  8; z_bus  in  8.
REQ-016 cond_ext  in  7  external conditions for cond_sel 7..13 (bit0 = dma_req ... bit6 = displayreg_load).
REQ-017 dma_req  in  1; int_pending  in  1: interruption requests.
REQ-018 u_address  out  UADDR_W  registered micro-address driving the external control-store ROM.
REQ-019 u_flags  out  4  registered {of,sf,cf,zf} micro-flags.
REQ-020 stack_level  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
REQ-021 stack_err  out  1  sticky overflow/underflow flag.

Function
REQ-022 Condition: cond_sel 0..3 = zf,cf,sf,of of the cond_flag_src-selected set; 4 = sf^of; 5 = (sf^of)|zf; 6 = cf|zf; 7..13 = cond_ext[cond_sel-7]; 14,15 = 0; result is XORed with cond_invert.
REQ-023 typ 000: u_address <= u_address + sign-extended offset, modulo 2^UADDR_W.
REQ-024 typ 001: condition true -> as typ 000; false -> u_address + 1.
REQ-025 typ 010: u_address <= TRAP_U_ADDR if dma_req|int_pending, else FETCH_U_ADDR.
REQ-026 typ 011: u_address <= DISPATCH_BASE + zero-extended ir, modulo 2^UADDR_W.
REQ-027 typ 100 (call): push u_address+1, then branch as typ 000.
REQ-028 typ 101 (return): pop; u_address <= popped entry.
REQ-029 typ 110: u_address <= zero-extended offset (absolute); typ 111: u_address held.
REQ-030 Call with stack full: no push, branch still taken, stack_err set.
REQ-031 Return with stack empty: u_address <= FETCH_U_ADDR, stack_err set.
REQ-032 stall has priority over typ; no push/pop, flag update or stack_err change occurs while stall=1.
REQ-033 u_zf: 00/11 hold, 01 alu zf, 10 alu zf & u_zf; u_cf: 00 hold, 01 alu_final_cf, 10 alu_out[0], 11 alu_out[7]; u_sf: 1 = z_bus[7]; u_of: 1 = alu_of.
REQ-034 Latency: u_address and u_flags reflect inputs one clk edge after sampling; condition uses the pre-edge u_flags.

Reset
REQ-035 arst=1 at a clk edge: u_address=0, u_flags=0, stack_level=0, stack_err=0, stack contents don't-care; arst overrides stall.
REQ-036 arst asserted mid-call/return discards the operation; first post-reset address is 0.

Configuration
REQ-037 Macro UCODE_SEQ_STACK_EN defined: stack, typ 100/101 and stack_err as specified.
REQ-038 Macro UCODE_SEQ_STACK_EN undefined: no stack storage; typ 100 acts as typ 000, typ 101 acts as typ 010; stack_level and stack_err tied 0.

Verification
REQ-039 arst 1 cycle, then typ=000, offset='h05 for 3 cycles -> u_address 0, 5, 'hA, 'hF.
REQ-040 u_address='h10, typ=000, offset=7'h7E (-2) -> 'h0E; u_address='h3FFF, offset 1 -> 0.
REQ-041 cond_flag_src=0, alu_flags zf=1, cond_sel=0, typ=001, offset 4 at 'h20 -> 'h24; with cond_invert=1 -> 'h21.
REQ-042 STACK_DEPTH=2, calls at 'h30 and 'h40 then third call -> stack_level 2, stack_err 1; two returns -> 'h41, 'h31; third return -> FETCH_U_ADDR.
REQ-043 typ=010 with int_pending=1 -> TRAP_U_ADDR; typ=011, ir='hA5, DISPATCH_BASE='h100 -> 'h1A5; stall=1 during either -> address unchanged.
REQ-044 u_cf_in_src=11, alu_out='h80 -> u_cf=1; arst during a pending return -> u_address 0, stack_level 0.
